// File: rtl/rename_regfile_ckpt_if.sv
// Bus between the rename register file and its clients: decoder lookups,
// issue-time renaming, ROB commit, and branch checkpoint save/restore/flush.
interface rename_regfile_ckpt_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int ROB_W = 4,
  parameter int NRD   = 2,
  parameter int NCKPT = 4
);
  localparam int RI_W = $clog2(NREG);
  localparam int CK_W = $clog2(NCKPT);

  // Decoder operand lookups (combinational).
  logic [NRD*RI_W-1:0]  q_rs;
  logic [NRD*XLEN-1:0]  q_val;
  logic [NRD-1:0]       q_busy;
  logic [NRD*ROB_W-1:0] q_tag;

  // Rename of a destination register at issue.
  logic                 iss_en;
  logic [RI_W-1:0]      iss_rd;
  logic [ROB_W-1:0]     iss_tag;

  // ROB commit.
  logic                 cmt_en;
  logic [RI_W-1:0]      cmt_rd;
  logic [XLEN-1:0]      cmt_val;
  logic [ROB_W-1:0]     cmt_tag;

  // Checkpoint control and full flush.
  logic                 ck_save;
  logic [CK_W-1:0]      ck_save_id;
  logic                 ck_rest;
  logic [CK_W-1:0]      ck_rest_id;
  logic                 flush;

  // Client side: decoder, issue stage and ROB.
  modport master (
    output q_rs, iss_en, iss_rd, iss_tag, cmt_en, cmt_rd, cmt_val, cmt_tag,
           ck_save, ck_save_id, ck_rest, ck_rest_id, flush,
    input  q_val, q_busy, q_tag
  );

  // Register file side.
  modport slave (
    input  q_rs, iss_en, iss_rd, iss_tag, cmt_en, cmt_rd, cmt_val, cmt_tag,
           ck_save, ck_save_id, ck_rest, ck_rest_id, flush,
    output q_val, q_busy, q_tag
  );
endinterface

// File: rtl/rename_regfile_ckpt.sv
// Architectural register file with a rename table (busy + ROB tag per
// register) and NCKPT rename-table checkpoints for branch recovery.
// Lookups are combinational with a same-cycle commit bypass; values are
// never rolled back, only busy/tag mappings are checkpointed.
module rename_regfile_ckpt #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int ROB_W = 4,
  parameter int NRD   = 2,
  parameter int NCKPT = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 rdy,
  rename_regfile_ckpt_if.slave bus
);
  localparam int RI_W = $clog2(NREG);

  // Architectural state.
  logic [XLEN-1:0]  val  [NREG];
  logic [NREG-1:0]  busy;
  logic [ROB_W-1:0] tag  [NREG];

  // Checkpoint slots: mapping only, no values.
  logic [NREG-1:0]  ck_busy [NCKPT];
  logic [ROB_W-1:0] ck_tag  [NCKPT][NREG];

  // Intermediate (after commit clearing) and next-state mapping.
  logic [NREG-1:0]  busy_c, busy_n;
  logic [ROB_W-1:0] tag_c [NREG];
  logic [ROB_W-1:0] tag_n [NREG];
  logic [NREG-1:0]  ckb_c [NCKPT];
  logic [ROB_W-1:0] ckt_c [NCKPT][NREG];
  logic [NREG-1:0]  ckb_n [NCKPT];
  logic [ROB_W-1:0] ckt_n [NCKPT][NREG];

  // One-hot selects; x0 never commits or renames.
  logic            cmt_wr;
  logic            iss_ok;
  logic            save_ok;
  logic [NREG-1:0] cmt_sel;
  logic [NREG-1:0] iss_sel;

  assign cmt_wr  = bus.cmt_en && (bus.cmt_rd != '0);
  assign iss_ok  = bus.iss_en && (bus.iss_rd != '0) && !bus.flush && !bus.ck_rest;
  assign save_ok = bus.ck_save && !bus.flush && !bus.ck_rest;
  assign cmt_sel = cmt_wr ? (NREG'(1) << bus.cmt_rd) : '0;
  assign iss_sel = iss_ok ? (NREG'(1) << bus.iss_rd) : '0;

  // Lookup ports: x0 reads zero, a matching commit bypasses the table.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [RI_W-1:0] rs;
    logic            hit;
    assign rs  = bus.q_rs[k*RI_W +: RI_W];
    assign hit = rdy && bus.cmt_en && (bus.cmt_rd == rs) && busy[rs]
                 && (tag[rs] == bus.cmt_tag);
    assign bus.q_val[k*XLEN +: XLEN]   = (rs == '0) ? '0 : (hit ? bus.cmt_val : val[rs]);
    assign bus.q_busy[k]               = (rs != '0) && !hit && busy[rs];
    assign bus.q_tag[k*ROB_W +: ROB_W] = ((rs == '0) || hit) ? '0 : tag[rs];
  end

  // Next mapping: commit clear, then save, then flush/restore, then issue.
  always_comb begin
    // NOTE: every variable gets a full default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    busy_c = busy;
    tag_c  = tag;
    ckb_c  = ck_busy;
    ckt_c  = ck_tag;

    // Commit clears the live entry and every snapshot entry still waiting
    // on the committing tag; stale commits leave newer renames alone.
    for (int r = 0; r < NREG; r++) begin
      if (cmt_sel[r] && busy[r] && (tag[r] == bus.cmt_tag)) begin
        busy_c[r] = 1'b0;
        tag_c[r]  = '0;
      end
      for (int s = 0; s < NCKPT; s++) begin
        if (cmt_sel[r] && ck_busy[s][r] && (ck_tag[s][r] == bus.cmt_tag)) begin
          ckb_c[s][r] = 1'b0;
          ckt_c[s][r] = '0;
        end
      end
    end

    // Snapshot captures the post-commit, pre-issue mapping.
    ckb_n = ckb_c;
    ckt_n = ckt_c;
    if (save_ok) begin
      ckb_n[bus.ck_save_id] = busy_c;
      for (int r = 0; r < NREG; r++) ckt_n[bus.ck_save_id][r] = tag_c[r];
    end

    // Recovery has priority over normal update; issue overrides commit.
    busy_n = busy_c;
    tag_n  = tag_c;
    if (bus.flush) begin
      busy_n = '0;
      for (int r = 0; r < NREG; r++) tag_n[r] = '0;
    end else if (bus.ck_rest) begin
      busy_n = ckb_c[bus.ck_rest_id];
      for (int r = 0; r < NREG; r++) tag_n[r] = ckt_c[bus.ck_rest_id][r];
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (iss_sel[r]) begin
          busy_n[r] = 1'b1;
          tag_n[r]  = bus.iss_tag;
        end
      end
    end
  end

  // State update, frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the value file and snapshots are reset too, because a lookup
      // of a never-written register must architecturally return zero.
      busy <= '0;
      for (int r = 0; r < NREG; r++) begin
        val[r] <= '0;
        tag[r] <= '0;
      end
      for (int s = 0; s < NCKPT; s++) begin
        ck_busy[s] <= '0;
        for (int r = 0; r < NREG; r++) ck_tag[s][r] <= '0;
      end
    end else if (rdy) begin
      // NOTE: non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      if (cmt_wr) val[bus.cmt_rd] <= bus.cmt_val;
      busy    <= busy_n;
      tag     <= tag_n;
      ck_busy <= ckb_n;
      ck_tag  <= ckt_n;
    end
  end
endmodule
